rf_write_arbiter: RTL and testbench

Shares the single write port (we3/a3/wd3) of the 32×32 register file between several writeback sources (ALU pipeline, load/store unit, CSR/mul-div unit). Per-requester valid/ready handshake, fair round-robin arbitration, and one registered output stage driving the register file. Publishes a pending-write mask so hazard logic can stall reads of registers whose write has been granted but not yet committed.

---
 rtl/rf_arb_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rf_write_arbiter.sv | 50 +++++
 tb/tb_rf_write_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and writeback request type for the register-file write arbiter
package rf_arb_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NREGS    = 32;
    localparam int NREQ_DEF = 2;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among NREQ requesters; pointer moves only on a grant
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);
    logic [IW-1:0] last_grant;
    int j;
    // scan farthest-first so the nearest requester after last_grant overwrites the rest
    always_comb begin
        grant = '0;
        grant_idx = '0;
        j = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last_grant) + k) % NREQ;
            grant = (en && req[j]) ? NREQ'(1) << j : grant;
            grant_idx = (en && req[j]) ? IW'(j) : grant_idx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= IW'(NREQ - 1);
        else if (|grant)
            last_grant <= grant_idx;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port with one registered stage
module rf_write_arbiter #(
    parameter int NREQ = rf_arb_pkg::NREQ_DEF,
    parameter int XLEN = rf_arb_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][4:0]       req_rd,
    input  logic [NREQ-1:0][XLEN-1:0]  req_wd,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       hold,
    output logic                       rf_we,
    output logic [4:0]                 rf_a3,
    output logic [XLEN-1:0]            rf_wd,
    output logic [31:0]                pend_mask
);
    import rf_arb_pkg::*;
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic              stage_valid;
    logic [REG_AW-1:0] stage_rd;
    logic [XLEN-1:0]   stage_wd;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (rst_n && !hold),
        .grant     (grant),
        .grant_idx (gidx)
    );
    assign req_ready = grant;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_rd <= '0;
            stage_wd <= '0;
        end else begin
            stage_valid <= |grant;
            stage_rd <= |grant ? req_rd[gidx] : '0;
            stage_wd <= |grant ? req_wd[gidx] : '0;
        end
    end
    // x0 writes complete the handshake but never reach the port or the hazard mask
    assign rf_we = stage_valid && stage_rd != '0;
    assign rf_a3 = stage_valid ? stage_rd : '0;
    assign rf_wd = stage_valid ? stage_wd : '0;
    assign pend_mask = rf_we ? NREGS'(1) << stage_rd : '0;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of handshake, round-robin order, x0 suppression, hold and fairness
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]        valid2, ready2;
    logic [1:0][4:0]   rd2;
    logic [1:0][31:0]  wd2;
    logic              hold2, we2;
    logic [4:0]        a32;
    logic [31:0]       wd32, pm2;
    logic [2:0]        valid3, ready3;
    logic [2:0][4:0]   rd3;
    logic [2:0][31:0]  wd3;
    logic              hold3, we3;
    logic [4:0]        a33;
    logic [31:0]       wd33, pm3;
    rf_write_arbiter #(.NREQ(2), .XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_rd(rd2), .req_wd(wd2),
        .req_ready(ready2), .hold(hold2), .rf_we(we2), .rf_a3(a32), .rf_wd(wd32), .pend_mask(pm2)
    );
    rf_write_arbiter #(.NREQ(3), .XLEN(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_rd(rd3), .req_wd(wd3),
        .req_ready(ready3), .hold(hold3), .rf_we(we3), .rf_a3(a33), .rf_wd(wd33), .pend_mask(pm3)
    );
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) if (we2) rf[a32] <= wd32;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    logic [1:0] exp_rdy;
    int cnt [3];
    int lastc [3];
    int maxw, w;
    initial begin
        valid2 = '0; rd2 = '0; wd2 = '0; hold2 = 1'b0;
        valid3 = '0; rd3 = {5'd3, 5'd2, 5'd1}; wd3 = '0; hold3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        valid2 = 2'b11; rd2 = {5'd6, 5'd5}; wd2 = {32'h22, 32'h11};
        #1;
        check("rst_ready", 64'(ready2), 64'h0);
        check("rst_we", 64'(we2), 64'h0);
        rst_n = 1'b1;
        #1;
        check("first_ready", 64'(ready2), 64'h1);
        tick();
        check("first_we", 64'(we2), 64'h1);
        check("first_a3", 64'(a32), 64'h5);
        rst_n = 1'b0;
        #1;
        check("async_we", 64'(we2), 64'h0);
        check("async_pm", 64'(pm2), 64'h0);
        check("async_ready", 64'(ready2), 64'h0);
        check("async_a3", 64'(a32), 64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(ready2), 64'h1);
        exp_rdy = 2'b01;
        for (int i = 0; i < 6; i++) begin
            check("cont_ready", 64'(ready2), 64'(exp_rdy));
            tick();
            check("cont_a3", 64'(a32), exp_rdy == 2'b01 ? 64'h5 : 64'h6);
            check("cont_pm", 64'(pm2), exp_rdy == 2'b01 ? 64'h20 : 64'h40);
            exp_rdy = ~exp_rdy;
        end
        valid2 = 2'b00;
        tick();
        check("idle_we", 64'(we2), 64'h0);
        check("x5", 64'(rf[5]), 64'h11);
        check("x6", 64'(rf[6]), 64'h22);
        rd2[0] = 5'd0; wd2[0] = 32'hDEADBEEF; valid2 = 2'b01;
        #1;
        check("x0_ready", 64'(ready2), 64'h1);
        tick();
        valid2 = 2'b00;
        check("x0_we", 64'(we2), 64'h0);
        check("x0_pm", 64'(pm2), 64'h0);
        check("x0_wd", 64'(wd32), 64'hDEADBEEF);
        tick();
        check("x0_read", 64'(rf[0]), 64'h0);
        rd2 = {5'd7, 5'd7}; wd2 = {32'h1, 32'h2}; valid2 = 2'b11;
        #1;
        check("same_ready1", 64'(ready2), 64'h2);
        tick();
        valid2 = 2'b01;
        check("same_pm1", 64'(pm2), 64'h80);
        check("same_wd1", 64'(wd32), 64'h1);
        #1;
        check("same_ready0", 64'(ready2), 64'h1);
        tick();
        valid2 = 2'b00;
        check("same_pm2", 64'(pm2), 64'h80);
        check("same_wd2", 64'(wd32), 64'h2);
        tick();
        check("same_pm_clr", 64'(pm2), 64'h0);
        check("x7", 64'(rf[7]), 64'h2);
        rd2 = {5'd6, 5'd5}; wd2 = {32'h44, 32'h33}; valid2 = 2'b11;
        #1;
        check("hold_pre", 64'(ready2), 64'h2);
        tick();
        hold2 = 1'b1;
        #1;
        check("hold_ready", 64'(ready2), 64'h0);
        check("hold_drain_we", 64'(we2), 64'h1);
        check("hold_drain_a3", 64'(a32), 64'h6);
        repeat (3) begin
            tick();
            check("hold_ready_n", 64'(ready2), 64'h0);
            check("hold_we_n", 64'(we2), 64'h0);
        end
        hold2 = 1'b0;
        #1;
        check("hold_resume", 64'(ready2), 64'h1);
        tick();
        check("hold_a3", 64'(a32), 64'h5);
        check("hold_wd", 64'(wd32), 64'h33);
        valid2 = 2'b00;
        tick();
        valid3 = 3'b111;
        maxw = 0;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            lastc[i] = -1;
        end
        for (int c = 0; c < 30; c++) begin
            #1;
            if (c == 0) check("fair_first", 64'(ready3), 64'h1);
            for (int i = 0; i < 3; i++) begin
                if (ready3[i]) begin
                    w = c - lastc[i] - 1;
                    maxw = w > maxw ? w : maxw;
                    lastc[i] = c;
                    cnt[i]++;
                end
            end
            tick();
        end
        valid3 = 3'b000;
        check("fair_cnt0", 64'(cnt[0]), 64'd10);
        check("fair_cnt1", 64'(cnt[1]), 64'd10);
        check("fair_cnt2", 64'(cnt[2]), 64'd10);
        check("fair_maxgap", 64'(maxw), 64'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
